// File: rtl/otter_mem_pkg.sv
// Shared definitions for the OTTER data-port memory path: access sizes,
// the memory-mapped IO boundary and the alignment rule used by every requester.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  localparam logic [31:0] IO_BASE = 32'h11000000;

  // Size 3 is deliberately treated as aligned; the memory ignores it.
  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] size);
    misaligned = 1'b0;
    if (size == HALF) misaligned = addr[0];
    else if (size == WORD) misaligned = |addr[1:0];
  endfunction

endpackage

// File: rtl/otter_rr_arb2.sv
// Two-way round-robin grant with a lock override that hands every tie to B.
module otter_rr_arb2
  import otter_mem_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  prio_t      prio,
  input  logic       lock_b,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req_a && req_b) gnt = (lock_b || prio == PRIO_B) ? 2'b10 : 2'b01;
    else if (req_a)     gnt = 2'b01;
    else if (req_b)     gnt = 2'b10;
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbitrates the CPU (A) and DMA/debug master (B) onto memory port 2 and
// returns exactly one response pulse per granted command, one cycle later.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = 4
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RST_N,
  input  logic        A_REQ,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic        A_WE,
  input  logic [1:0]  A_SIZE,
  input  logic        A_SIGN,
  input  logic        B_REQ,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_DIN,
  input  logic        B_WE,
  input  logic [1:0]  B_SIZE,
  input  logic        B_SIGN,
  input  logic        B_LOCK,
  output logic        A_GNT,
  output logic        A_RVALID,
  output logic [31:0] A_RDATA,
  output logic        A_RERR,
  output logic        B_GNT,
  output logic        B_RVALID,
  output logic [31:0] B_RDATA,
  output logic        B_RERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  prio_t            prio;
  logic             locked;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_b;
  logic             req_a;
  logic             req_b;
  logic [1:0]       gnt;

  logic [31:0] cmd_addr;
  logic [31:0] cmd_din;
  logic        cmd_we;
  logic [1:0]  cmd_size;
  logic        cmd_sign;
  logic        cmd_mis;

  logic        rsp_v;
  logic        rsp_owner;
  logic        rsp_rd;
  logic        rsp_err;
  logic [31:0] rd_data;

  // Requests are masked while in reset so no grant can leak out of it.
  assign req_a = A_REQ & MEM_RST_N;
  assign req_b = B_REQ & MEM_RST_N;

  // Dropping B_LOCK releases the lock in the same cycle; a full count yields one tie to A.
  assign lock_b = locked && B_LOCK && (lock_cnt < CNT_W'(MAX_LOCK));

  otter_rr_arb2 u_arb (
    .req_a  (req_a),
    .req_b  (req_b),
    .prio   (prio),
    .lock_b (lock_b),
    .gnt    (gnt)
  );

  assign A_GNT = gnt[0];
  assign B_GNT = gnt[1];

  always_comb begin
    cmd_addr = '0;
    cmd_din  = '0;
    cmd_we   = 1'b0;
    cmd_size = 2'd0;
    cmd_sign = 1'b0;
    if (gnt[1]) begin
      cmd_addr = B_ADDR;
      cmd_din  = B_DIN;
      cmd_we   = B_WE;
      cmd_size = B_SIZE;
      cmd_sign = B_SIGN;
    end else if (gnt[0]) begin
      cmd_addr = A_ADDR;
      cmd_din  = A_DIN;
      cmd_we   = A_WE;
      cmd_size = A_SIZE;
      cmd_sign = A_SIGN;
    end
    cmd_mis = misaligned(cmd_addr, cmd_size);
  end

  assign MEM_ADDR2  = cmd_addr;
  assign MEM_DIN2   = cmd_din;
  assign MEM_SIZE   = cmd_size;
  assign MEM_SIGN   = cmd_sign;
  assign MEM_READ2  = (|gnt) && !cmd_we && !cmd_mis;
  assign MEM_WRITE2 = (|gnt) && cmd_we && !cmd_mis;

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      prio     <= PRIO_A;
      locked   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      if (gnt[0])      prio <= PRIO_B;
      else if (gnt[1]) prio <= PRIO_A;

      if (!B_LOCK || !B_REQ) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (gnt[1]) begin
        locked <= 1'b1;
        if (lock_cnt != CNT_W'(MAX_LOCK)) lock_cnt <= lock_cnt + CNT_W'(1);
      end else if (gnt[0]) begin
        lock_cnt <= '0;
      end
    end
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      rsp_v     <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_v     <= |gnt;
      rsp_owner <= gnt[1];
      rsp_rd    <= !cmd_we;
      rsp_err   <= cmd_mis;
    end
  end

  assign rd_data  = (rsp_rd && !rsp_err) ? MEM_DOUT2 : '0;
  assign A_RVALID = rsp_v && !rsp_owner;
  assign B_RVALID = rsp_v && rsp_owner;
  assign A_RERR   = A_RVALID && rsp_err;
  assign B_RERR   = B_RVALID && rsp_err;
  assign A_RDATA  = A_RVALID ? rd_data : '0;
  assign B_RDATA  = B_RVALID ? rd_data : '0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a small byte-addressed memory
// model standing in for the OTTER data port.
module tb_otter_mem_arbiter;
  import otter_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, a_sign = 1'b0;
  logic [31:0] a_addr = '0, a_din = '0;
  logic [1:0]  a_size = 2'd0;
  logic        b_req = 1'b0, b_we = 1'b0, b_sign = 1'b0, b_lock = 1'b0;
  logic [31:0] b_addr = '0, b_din = '0;
  logic [1:0]  b_size = 2'd0;
  logic        a_gnt, a_rvalid, a_rerr, b_gnt, b_rvalid, b_rerr;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr2, mem_din2;
  logic        mem_write2, mem_read2, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_dout2 = '0;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  otter_mem_arbiter #(.MAX_LOCK(8), .CNT_W(4)) dut (
    .MEM_CLK(clk), .MEM_RST_N(rst_n),
    .A_REQ(a_req), .A_ADDR(a_addr), .A_DIN(a_din), .A_WE(a_we), .A_SIZE(a_size), .A_SIGN(a_sign),
    .B_REQ(b_req), .B_ADDR(b_addr), .B_DIN(b_din), .B_WE(b_we), .B_SIZE(b_size), .B_SIGN(b_sign),
    .B_LOCK(b_lock),
    .A_GNT(a_gnt), .A_RVALID(a_rvalid), .A_RDATA(a_rdata), .A_RERR(a_rerr),
    .B_GNT(b_gnt), .B_RVALID(b_rvalid), .B_RDATA(b_rdata), .B_RERR(b_rerr),
    .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2), .MEM_WRITE2(mem_write2), .MEM_READ2(mem_read2),
    .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2)
  );

  // Little-endian memory; SIGN=1 means unsigned load. IO space writes are dropped.
  function automatic logic [31:0] mem_rd(input logic [31:0] addr, input logic [1:0] size, input logic sign);
    logic [9:0] a;
    logic [7:0] b0;
    logic [15:0] h;
    a = addr[9:0];
    b0 = mem[a];
    h = {mem[a + 10'd1], mem[a]};
    case (size)
      2'd0:    mem_rd = sign ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'd1:    mem_rd = sign ? {16'd0, h} : {{16{h[15]}}, h};
      default: mem_rd = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_read2) mem_dout2 <= mem_rd(mem_addr2, mem_size, mem_sign);
    if (mem_write2 && mem_addr2 < IO_BASE) begin
      case (mem_size)
        2'd0: mem[mem_addr2[9:0]] <= mem_din2[7:0];
        2'd1: begin
          mem[mem_addr2[9:0]]         <= mem_din2[7:0];
          mem[mem_addr2[9:0] + 10'd1] <= mem_din2[15:8];
        end
        2'd2: begin
          mem[mem_addr2[9:0]]         <= mem_din2[7:0];
          mem[mem_addr2[9:0] + 10'd1] <= mem_din2[15:8];
          mem[mem_addr2[9:0] + 10'd2] <= mem_din2[23:16];
          mem[mem_addr2[9:0] + 10'd3] <= mem_din2[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_req = 1'b0; a_we = 1'b0; a_sign = 1'b0; a_addr = '0; a_din = '0; a_size = 2'd0;
    b_req = 1'b0; b_we = 1'b0; b_sign = 1'b0; b_addr = '0; b_din = '0; b_size = 2'd0;
    b_lock = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 32'h100; a_size = 2'd2;
    b_req = 1'b1; b_addr = 32'h300; b_size = 2'd2;
    @(negedge clk);
    total++; if (a_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_gnt: got %0b want 0", a_gnt); end
    total++; if (b_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_gnt: got %0b want 0", b_gnt); end
    total++; if (mem_read2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_read2: got %0b want 0", mem_read2); end
    total++; if (mem_addr2 !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr2: got %h want 0", mem_addr2); end
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got a=%0b b=%0b want 0", a_rvalid, b_rvalid); end
    total++; if (a_rdata !== 32'h0 || a_rerr !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_rsp: got rdata=%h rerr=%0b want 0", a_rdata, a_rerr); end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_a_load;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_size = 2'd2;
    @(negedge clk);
    total++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin bad++; $display("[TB] FAIL load_gnt: got a=%0b b=%0b want a=1 b=0", a_gnt, b_gnt); end
    total++; if (mem_read2 !== 1'b1 || mem_write2 !== 1'b0) begin bad++; $display("[TB] FAIL load_mem_read2: got rd=%0b wr=%0b want rd=1 wr=0", mem_read2, mem_write2); end
    total++; if (mem_addr2 !== 32'h100 || mem_size !== 2'd2) begin bad++; $display("[TB] FAIL load_mem_cmd: got addr=%h size=%0d want 100/2", mem_addr2, mem_size); end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL load_a_rvalid: got %0b want 1", a_rvalid); end
    total++; if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_a_rdata: got %h want deadbeef", a_rdata); end
    total++; if (a_rerr !== 1'b0) begin bad++; $display("[TB] FAIL load_a_rerr: got %0b want 0", a_rerr); end
    total++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin bad++; $display("[TB] FAIL load_b_quiet: got rvalid=%0b rdata=%h want 0", b_rvalid, b_rdata); end
    tick();
  endtask

  task automatic test_alternate;
    logic exp_b;
    logic prev_b;
    do_reset();
    a_we = 1'b0; a_addr = 32'h100; a_size = 2'd2;
    b_we = 1'b0; b_addr = 32'h300; b_size = 2'd2;
    for (int i = 0; i < 7; i++) begin
      a_req = (i < 6);
      b_req = (i < 6);
      exp_b = i[0];
      prev_b = ~i[0];
      @(negedge clk);
      if (i < 6) begin
        total++; if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin bad++; $display("[TB] FAIL alt_gnt[%0d]: got a=%0b b=%0b want b=%0b", i, a_gnt, b_gnt, exp_b); end
      end
      if (i > 0) begin
        if (prev_b) begin
          total++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h44332211 || a_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL alt_rsp_b[%0d]: got bv=%0b bd=%h av=%0b want 1/44332211/0", i, b_rvalid, b_rdata, a_rvalid); end
        end else begin
          total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL alt_rsp_a[%0d]: got av=%0b ad=%h bv=%0b want 1/deadbeef/0", i, a_rvalid, a_rdata, b_rvalid); end
        end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    total++; if (mem_addr2 !== 32'h0 || mem_read2 !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL idle_outputs: got addr=%h rd=%0b av=%0b bv=%0b want 0", mem_addr2, mem_read2, a_rvalid, b_rvalid); end
    tick();
  endtask

  task automatic test_lock;
    logic exp_b;
    a_we = 1'b0; a_addr = 32'h100; a_size = 2'd2;
    b_we = 1'b0; b_addr = 32'h300; b_size = 2'd2;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b_lock = (i < 11);
      exp_b = ((i >= 1) && (i <= 8)) || (i == 10) || (i == 12);
      @(negedge clk);
      total++; if (a_gnt !== ~exp_b || b_gnt !== exp_b) begin bad++; $display("[TB] FAIL lock_gnt[%0d]: got a=%0b b=%0b want b=%0b", i, a_gnt, b_gnt, exp_b); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_misaligned;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h102; a_size = 2'd2; a_din = 32'h12345678;
    @(negedge clk);
    total++; if (a_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mis_a_gnt: got %0b want 1", a_gnt); end
    total++; if (mem_write2 !== 1'b0 || mem_read2 !== 1'b0) begin bad++; $display("[TB] FAIL mis_mem_strobe: got wr=%0b rd=%0b want 0", mem_write2, mem_read2); end
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h103; a_size = 2'd3;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b1 || a_rerr !== 1'b1 || a_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mis_a_rsp: got v=%0b e=%0b d=%h want 1/1/0", a_rvalid, a_rerr, a_rdata); end
    total++; if (mem[10'h102] !== 8'hAD) begin bad++; $display("[TB] FAIL mis_mem_kept: got %h want ad", mem[10'h102]); end
    total++; if (mem_read2 !== 1'b1 || mem_size !== 2'd3) begin bad++; $display("[TB] FAIL size3_forward: got rd=%0b size=%0d want 1/3", mem_read2, mem_size); end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b1 || a_rerr !== 1'b0) begin bad++; $display("[TB] FAIL size3_rsp: got v=%0b e=%0b want 1/0", a_rvalid, a_rerr); end
    idle_inputs();
    tick();
  endtask

  task automatic test_byte_store_load;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h201; b_size = 2'd0; b_din = 32'h0000005A;
    @(negedge clk);
    total++; if (b_gnt !== 1'b1 || mem_write2 !== 1'b1) begin bad++; $display("[TB] FAIL sb_gnt: got gnt=%0b wr=%0b want 1/1", b_gnt, mem_write2); end
    total++; if (mem_addr2 !== 32'h201 || mem_din2 !== 32'h5A) begin bad++; $display("[TB] FAIL sb_cmd: got addr=%h din=%h want 201/5a", mem_addr2, mem_din2); end
    tick();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h201; a_size = 2'd0; a_sign = 1'b1;
    @(negedge clk);
    total++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0 || b_rerr !== 1'b0) begin bad++; $display("[TB] FAIL sb_rsp: got v=%0b d=%h e=%0b want 1/0/0", b_rvalid, b_rdata, b_rerr); end
    total++; if (a_gnt !== 1'b1 || a_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL lbu_gnt: got gnt=%0b rv=%0b want 1/0", a_gnt, a_rvalid); end
    tick();
    a_addr = 32'h203; a_sign = 1'b0;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0000005A) begin bad++; $display("[TB] FAIL lbu_data: got v=%0b d=%h want 1/0000005a", a_rvalid, a_rdata); end
    tick();
    a_req = 1'b0;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL lb_data: got v=%0b d=%h want 1/ffffff80", a_rvalid, a_rdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_io_store;
    b_req = 1'b1; b_we = 1'b1; b_addr = IO_BASE; b_size = 2'd2; b_din = 32'hCAFE0001;
    @(negedge clk);
    total++; if (b_gnt !== 1'b1 || mem_write2 !== 1'b1 || mem_addr2 !== IO_BASE) begin bad++; $display("[TB] FAIL io_cmd: got gnt=%0b wr=%0b addr=%h want 1/1/11000000", b_gnt, mem_write2, mem_addr2); end
    tick();
    b_req = 1'b0;
    @(negedge clk);
    total++; if (b_rvalid !== 1'b1 || b_rerr !== 1'b0 || b_rdata !== 32'h0) begin bad++; $display("[TB] FAIL io_rsp: got v=%0b e=%0b d=%h want 1/0/0", b_rvalid, b_rerr, b_rdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_size = 2'd2;
    @(negedge clk);
    total++; if (a_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_gnt: got %0b want 1", a_gnt); end
    tick();
    rst_n = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_drop: got v=%0b d=%h want 0/0", a_rvalid, a_rdata); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_pulse: got %0b want 0", a_rvalid); end
    tick();
    a_req = 1'b1; b_req = 1'b1; b_addr = 32'h300; b_size = 2'd2;
    @(negedge clk);
    total++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_tie: got a=%0b b=%0b want a=1 b=0", a_gnt, b_gnt); end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'hEF; mem[10'h101] = 8'hBE; mem[10'h102] = 8'hAD; mem[10'h103] = 8'hDE;
    mem[10'h300] = 8'h11; mem[10'h301] = 8'h22; mem[10'h302] = 8'h33; mem[10'h303] = 8'h44;
    mem[10'h203] = 8'h80;

    test_reset();
    test_a_load();
    test_alternate();
    test_lock();
    test_misaligned();
    test_byte_store_load();
    test_io_store();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Two-requester arbiter for port 2 (data port) of the OTTER byte-addressable dual-port memory. It sits between the CPU data path (requester A) and a DMA/debug master (requester B). Each cycle it grants at most one command using round-robin priority and a bounded lock for B. Every granted command gets exactly one response pulse, routed to its owner one cycle later; misaligned accesses are filtered out and answered with an error.

## Interface
Parameters:
- `MAX_LOCK`, default 8: maximum consecutive grants B may hold with `B_LOCK` high before A gets one forced grant.
- `CNT_W`, default 4: width of the lock counter; must satisfy 2**CNT_W > MAX_LOCK.

Ports (X = A or B):
- `MEM_CLK` in, 1: clock shared with the memory.
- `MEM_RST_N` in, 1: asynchronous, active-low reset.
- `X_REQ` in, 1: command valid.
- `X_ADDR` in, 32: byte address.
- `X_DIN` in, 32: write data.
- `X_WE` in, 1: 1 = store, 0 = load.
- `X_SIZE` in, 2: 0 = byte, 1 = half, 2 = word.
- `X_SIGN` in, 1: 1 = unsigned load.
- `B_LOCK` in, 1: B requests exclusive back-to-back access.
- `X_GNT` out, 1: command accepted at this rising edge (combinational).
- `X_RVALID` out, 1: one-cycle response pulse.
- `X_RDATA` out, 32: load data; 0 for stores and errors.
- `X_RERR` out, 1: qualifies `X_RVALID`; misaligned command.
- `MEM_ADDR2` out, 32: memory-side command.
- `MEM_DIN2` out, 32: memory-side command.
- `MEM_WRITE2` out, 1: memory-side command.
- `MEM_READ2` out, 1: memory-side command.
- `MEM_SIZE` out, 2: memory-side command.
- `MEM_SIGN` out, 1: memory-side command.
- `MEM_DOUT2` in, 32: memory read data, valid one cycle after `MEM_READ2`.

## Operation
Arbitration:
- Only A requests: grant A. Only B requests: grant B.
- Both request: grant the requester named by `prio`, except while the lock is active (below).
- `prio` flips to the other requester after every grant.

Lock:
- A grant to B with `B_LOCK`=1 sets `locked` and increments `lock_cnt`.
- While `locked`, B wins every tie.
- When `lock_cnt` reaches `MAX_LOCK`, the next tie goes to A, then `lock_cnt` clears.
- `locked` clears on any cycle where `B_LOCK`=0 or B is not requesting.

Misalignment:
- Half access with addr[0]=1, or word access with addr[1:0]≠0, is misaligned.
- A misaligned command is still granted, but `MEM_READ2` and `MEM_WRITE2` stay 0.

Command forwarding:
- The granted command is driven combinationally onto the `MEM_*` outputs.
- Idle cycles drive all `MEM_*` outputs to 0.
- `SIZE`=3 is treated as aligned and forwarded; the memory ignores its write.

Response register:
- Captured on each grant: `rsp_v`, `rsp_owner`, `rsp_rd`, `rsp_err`.
- In the next cycle the owner's `RVALID`=1 and `RERR`=`rsp_err`.
- `RDATA` = `MEM_DOUT2` when `rsp_rd` && !`rsp_err`, otherwise 0.
- The non-owner sees `RVALID`=0 and `RDATA`=0.

## Timing
- Grant is combinational in cycle t; the memory samples the command at edge t.
- Response appears in cycle t+1, so throughput is one command per cycle.
- A new grant in t+1 does not disturb the t+1 response.
- Back-to-back grants alternate owners correctly; the response register is rewritten every cycle.
- Requester holds `X_*` stable while `X_REQ`=1 && `X_GNT`=0; it may change them the cycle after `GNT`.
- Store to an address ≥ 0x11000000: forwarded unchanged (the memory raises IO_WR); acknowledged like any store.
- Reset, async assert:
  - `prio`=A, `locked`=0, `lock_cnt`=0, `rsp_v`=0.
  - All `GNT`, `RVALID` and `RERR` outputs 0; `RDATA` 0; `MEM_*` 0.
- Reset mid-transaction drops the pending response; no pulse after deassert.
- First edge after deassert arbitrates normally.

## Structure
- Shared package `otter_mem_pkg`:
  - `mem_size_t` enum (BYTE=0, HALF=1, WORD=2).
  - `IO_BASE` = 32'h11000000.
  - Function `misaligned(addr, size)`, reused by the CPU load/store unit.
- One sub-module, `otter_rr_arb2`:
  - Inputs: the two requests, `prio`, lock override.
  - Outputs: one-hot grant.
- Lock counter, response register and muxing stay in the top.

## Test plan
- A-only load at addr 0x100 holding 0xDEADBEEF, `SIZE`=2 → `A_GNT` in t, `MEM_READ2`=1; `A_RVALID`=1, `A_RDATA`=0xDEADBEEF in t+1; `B_RVALID`=0.
- A and B requesting continuously for 6 cycles, no lock → grants A,B,A,B,A,B. Each response goes to the correct owner one cycle later.
- B_LOCK=1, both requesting, `MAX_LOCK`=8 → 8 B grants, then 1 A grant, then B again. Dropping `B_LOCK` restores alternation next tie.
- A store at 0x102 with `SIZE`=2 → `A_GNT`=1, `MEM_WRITE2`=0; t+1 `A_RVALID`=1, `A_RERR`=1, `A_RDATA`=0; memory unchanged.
- B byte store 0x5A to 0x201, then A `lbu` 0x201 next cycle → A `RDATA`=0x0000005A. A `lb` of 0x80 at 0x203 → 0xFFFFFF80.
- Assert `MEM_RST_N`=0 in the cycle after a granted load → `A_RVALID` stays 0 through reset. After deassert, A request wins a tie (`prio`=A).
